// File: rtl/nts_nonce_generator.sv
// Nonce generator for the NTS engine. A keyed 64-bit counter is run through an
// iterative add-rotate-xor mixer. Results go into a small FIFO so that most
// nonce requests are answered in the cycle after i_get. Configuration and
// status sit in an 8-word window on the dispatcher API bus.
module nts_nonce_generator #(
  parameter int                        API_ADDR_WIDTH  = 12,
  parameter int                        API_RW_WIDTH    = 32,
  parameter logic [API_ADDR_WIDTH-1:0] API_BASE        = 12'h300,
  parameter int                        FIFO_DEPTH_LOG2 = 2,
  parameter int                        ROUNDS          = 8
) (
  input  logic                      i_clk,
  input  logic                      i_areset,
  input  logic                      i_get,
  output logic                      o_ready,
  output logic [63:0]               o_data,
  input  logic                      i_api_cs,
  input  logic                      i_api_we,
  input  logic [API_ADDR_WIDTH-1:0] i_api_address,
  input  logic [API_RW_WIDTH-1:0]   i_api_write_data,
  output logic [API_RW_WIDTH-1:0]   o_api_read_data
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int R_W   = $clog2(ROUNDS + 1);
  localparam logic [R_W-1:0]   LAST_ROUND = R_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_KEY_HI = 3'd2;
  localparam logic [2:0] OFF_KEY_LO = 3'd3;
  localparam logic [2:0] OFF_CTR_HI = 3'd4;
  localparam logic [2:0] OFF_CTR_LO = 3'd5;
  localparam logic [2:0] OFF_SERVED = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  function automatic logic [63:0] rotl13(input logic [63:0] v);
    return {v[50:0], v[63:51]};
  endfunction

  state_t                    state_r, state_nx_s;
  logic                      enable_r, wrapped_r, pending_r, ready_r;
  logic [63:0]               key_r, ctr_r, x_r, data_r, mix_val_s, serve_data_s;
  logic [R_W-1:0]            round_r;
  logic [31:0]               served_r, rdata_s;
  logic [API_RW_WIDTH-1:0]   rdata_r;
  logic [63:0]               mem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]          count_r;
  logic [API_ADDR_WIDTH-1:0] off_full_s;
  logic [2:0]                off_s;
  logic hit_s, wr_s, rd_s, flush_s;
  logic load_s, mix_s, push_s;
  logic fifo_full_s, fifo_empty_s, serve_s, pop_s, bypass_s, fifo_wr_s;

  // API address decode; the window is 8 words starting at API_BASE
  always_comb begin
    off_full_s = i_api_address - API_BASE;
    hit_s      = (off_full_s < API_ADDR_WIDTH'(4'd8));
    off_s      = off_full_s[2:0];
    wr_s       = i_api_cs & i_api_we & hit_s;
    rd_s       = i_api_cs & ~i_api_we & hit_s;
    flush_s    = wr_s & (off_s == OFF_CTRL) & i_api_write_data[1];
  end

  // FIFO level flags and the request-serving decision (push bypasses an empty FIFO)
  always_comb begin
    fifo_full_s  = (count_r == FULL_CNT);
    fifo_empty_s = (count_r == {CNT_W{1'b0}});
    serve_s      = (pending_r | i_get) & ~flush_s & (~fifo_empty_s | push_s);
    pop_s        = serve_s & ~fifo_empty_s;
    bypass_s     = serve_s & fifo_empty_s;
    fifo_wr_s    = push_s & ~bypass_s;
    serve_data_s = fifo_empty_s ? x_r : mem_r[rd_ptr_r];
  end

  // Generator FSM state register
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Generator FSM next state; flush abandons any in-flight nonce
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_r && !fifo_full_s) state_nx_s = ST_MIX;
        else                          state_nx_s = ST_IDLE;
      end
      ST_MIX: begin
        if (round_r == LAST_ROUND) state_nx_s = ST_PUSH;
        else                       state_nx_s = ST_MIX;
      end
      ST_PUSH: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
    if (flush_s) state_nx_s = ST_IDLE;
    else         state_nx_s = state_nx_s;
  end

  // Generator FSM outputs: load the mixer, run a round, or push the result
  always_comb begin
    load_s = 1'b0;
    mix_s  = 1'b0;
    push_s = 1'b0;
    if (!flush_s) begin
      case (state_r)
        ST_IDLE: load_s = enable_r & ~fifo_full_s;
        ST_MIX:  mix_s  = 1'b1;
        ST_PUSH: push_s = 1'b1;
        default: load_s = 1'b0;
      endcase
    end else begin
      load_s = 1'b0;
      mix_s  = 1'b0;
      push_s = 1'b0;
    end
  end

  // One mixer round: rotate-xor, then add key and zero-extended round index
  always_comb begin
    mix_val_s = (rotl13(x_r) ^ x_r) + key_r + {{(64-R_W){1'b0}}, round_r};
  end

  // Mixer state and round counter
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      x_r     <= 64'd0;
      round_r <= {R_W{1'b0}};
    end else if (load_s) begin
      x_r     <= ctr_r ^ key_r;
      round_r <= {R_W{1'b0}};
    end else if (mix_s) begin
      x_r     <= mix_val_s;
      round_r <= round_r + R_W'(1'b1);
    end
  end

  // Configuration registers, counter advance and the sticky wrap flag
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      enable_r  <= 1'b0;
      key_r     <= 64'd0;
      ctr_r     <= 64'd0;
      wrapped_r <= 1'b0;
    end else begin
      if (push_s) begin
        ctr_r <= ctr_r + 64'd1;
        if (ctr_r == {64{1'b1}}) wrapped_r <= 1'b1;
      end
      if (flush_s) wrapped_r <= 1'b0;
      if (wr_s) begin
        case (off_s)
          OFF_CTRL:   enable_r <= i_api_write_data[0];
          OFF_KEY_HI: if (!enable_r) key_r[63:32] <= i_api_write_data[31:0];
          OFF_KEY_LO: if (!enable_r) key_r[31:0]  <= i_api_write_data[31:0];
          OFF_CTR_HI: if (!enable_r) ctr_r[63:32] <= i_api_write_data[31:0];
          OFF_CTR_LO: if (!enable_r) ctr_r[31:0]  <= i_api_write_data[31:0];
          default:    enable_r <= enable_r;
        endcase
      end
    end
  end

  // Nonce FIFO storage and pointers; flush empties it
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 64'd0;
      wr_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (fifo_wr_s) begin
        mem_r[wr_ptr_r] <= x_r;
        wr_ptr_r        <= wr_ptr_r + FIFO_DEPTH_LOG2'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + FIFO_DEPTH_LOG2'(1'b1);
      count_r <= count_r + CNT_W'(fifo_wr_s) - CNT_W'(pop_s);
    end
  end

  // Consumer side: single outstanding request, registered ready/data, served count
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      pending_r <= 1'b0;
      ready_r   <= 1'b0;
      data_r    <= 64'd0;
      served_r  <= 32'd0;
    end else begin
      ready_r <= serve_s;
      if (serve_s) begin
        data_r    <= serve_data_s;
        served_r  <= served_r + 32'd1;
        pending_r <= 1'b0;
      end else if (i_get) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Register read multiplexer
  always_comb begin
    case (off_s)
      OFF_CTRL:   rdata_s = {31'd0, enable_r};
      OFF_STATUS: rdata_s = {26'd0, wrapped_r, pending_r, 4'(count_r)};
      OFF_KEY_HI: rdata_s = key_r[63:32];
      OFF_KEY_LO: rdata_s = key_r[31:0];
      OFF_CTR_HI: rdata_s = ctr_r[63:32];
      OFF_CTR_LO: rdata_s = ctr_r[31:0];
      OFF_SERVED: rdata_s = served_r;
      default:    rdata_s = 32'd0;
    endcase
  end

  // Registered read data, zero whenever this block is not being read
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      rdata_r <= {API_RW_WIDTH{1'b0}};
    end else if (rd_s) begin
      rdata_r <= API_RW_WIDTH'(rdata_s);
    end else begin
      rdata_r <= {API_RW_WIDTH{1'b0}};
    end
  end

  assign o_ready         = ready_r;
  assign o_data          = data_r;
  assign o_api_read_data = rdata_r;

endmodule
